// File: rtl/reg_check_pkg.sv
// Shared definitions for the register-check harness: FSM encoding and parameter defaults.
package reg_check_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_NUM_REGS    = 32;
    localparam int DEFAULT_CYCLE_WIDTH = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_CHECK,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/reg_check_stage.sv
// Capture-and-compare stage: registers one swept register per CHECK cycle and
// compares it against the ROM word that arrives one cycle later.
module reg_check_stage
    import reg_check_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(DEFAULT_NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  capture,
    input  logic [ADDR_WIDTH-1:0] capture_reg,
    input  logic [DATA_WIDTH-1:0] capture_data,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic                  compare,
    output logic                  dump_valid,
    output logic [ADDR_WIDTH-1:0] dump_reg,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic [DATA_WIDTH-1:0] dump_exp,
    output logic                  mismatch
);

    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] reg_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            reg_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= capture;
            if (capture) begin
                reg_q  <= capture_reg;
                data_q <= capture_data;
            end
        end
    end

    // Data outputs are forced to zero whenever nothing valid is presented.
    always_comb begin
        dump_valid = valid_q;
        dump_reg   = valid_q ? reg_q    : '0;
        dump_data  = valid_q ? data_q   : '0;
        dump_exp   = valid_q ? exp_data : '0;
        mismatch   = valid_q && compare && (data_q != exp_data);
    end

endmodule

// File: rtl/reg_check_harness.sv
// Register-check harness: runs the processor for a cycle budget, then sweeps the
// regfile, dumping each register and optionally comparing against an expected ROM.
module reg_check_harness
    import reg_check_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS    = DEFAULT_NUM_REGS,
    parameter int CYCLE_WIDTH = DEFAULT_CYCLE_WIDTH,
    parameter int ADDR_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode,
    input  logic [CYCLE_WIDTH-1:0] num_cycles,
    input  logic [ADDR_WIDTH-1:0]  cpu_read_reg,
    output logic [ADDR_WIDTH-1:0]  read_reg,
    input  logic [DATA_WIDTH-1:0]  read_data,
    output logic [ADDR_WIDTH-1:0]  exp_addr,
    input  logic [DATA_WIDTH-1:0]  exp_data,
    output logic                   cpu_hold,
    output logic                   dump_valid,
    output logic [ADDR_WIDTH-1:0]  dump_reg,
    output logic [DATA_WIDTH-1:0]  dump_data,
    output logic                   mismatch,
    output logic [DATA_WIDTH-1:0]  dump_exp,
    output logic [CYCLE_WIDTH-1:0] cycle_count,
    output logic [ADDR_WIDTH:0]    error_count,
    output logic                   busy,
    output logic                   done,
    output logic                   pass
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                 state;
    state_t                 state_next;
    logic                   accept;
    logic                   mode_q;
    logic [CYCLE_WIDTH-1:0] budget_q;
    logic [CYCLE_WIDTH-1:0] count_inc;
    logic [ADDR_WIDTH-1:0]  sweep_idx;
    logic                   in_check;

    assign count_inc = cycle_count + 1'b1;
    assign in_check  = (state == ST_CHECK);
    assign read_reg  = in_check ? sweep_idx : cpu_read_reg;
    assign exp_addr  = sweep_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cpu_hold   = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        pass       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (num_cycles == '0) ? ST_CHECK : ST_RUN;
                end
            end
            ST_RUN: begin
                cpu_hold = 1'b0;
                busy     = 1'b1;
                if (count_inc == budget_q) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                busy = 1'b1;
                if (sweep_idx == LAST_IDX) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy       = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                pass = !mode_q || (error_count == '0);
                if (start) begin
                    accept     = 1'b1;
                    state_next = (num_cycles == '0) ? ST_CHECK : ST_RUN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The final mismatch (shown during DRAIN) is counted on the edge into DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q      <= 1'b0;
            budget_q    <= '0;
            cycle_count <= '0;
            error_count <= '0;
            sweep_idx   <= '0;
        end else if (accept) begin
            mode_q      <= mode;
            budget_q    <= num_cycles;
            cycle_count <= '0;
            error_count <= '0;
            sweep_idx   <= '0;
        end else begin
            if (state == ST_RUN) begin
                cycle_count <= count_inc;
            end
            if (in_check) begin
                sweep_idx <= (sweep_idx == LAST_IDX) ? '0 : sweep_idx + 1'b1;
            end
            if (mismatch) begin
                error_count <= error_count + 1'b1;
            end
        end
    end

    reg_check_stage #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_stage (
        .clock       (clock),
        .reset       (reset),
        .capture     (in_check),
        .capture_reg (sweep_idx),
        .capture_data(read_data),
        .exp_data    (exp_data),
        .compare     (mode_q),
        .dump_valid  (dump_valid),
        .dump_reg    (dump_reg),
        .dump_data   (dump_data),
        .dump_exp    (dump_exp),
        .mismatch    (mismatch)
    );

endmodule

// File: tb/tb_reg_check_harness.sv
// Self-checking bench for reg_check_harness: per-cycle timeline model of each run
// against a behavioural regfile/ROM, plus directed and randomized scenarios.
module tb_reg_check_harness;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int CW = 14;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [CW-1:0] num_cycles = '0;
    logic [AW-1:0] cpu_read_reg = '0;
    logic [AW-1:0] read_reg;
    logic [DW-1:0] read_data;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          cpu_hold;
    logic          dump_valid;
    logic [AW-1:0] dump_reg;
    logic [DW-1:0] dump_data;
    logic          mismatch;
    logic [DW-1:0] dump_exp;
    logic [CW-1:0] cycle_count;
    logic [AW:0]   error_count;
    logic          busy;
    logic          done;
    logic          pass;

    logic [DW-1:0] regfile [NR];
    logic [DW-1:0] rom [NR];

    int total = 0;
    int bad = 0;

    reg_check_harness #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .CYCLE_WIDTH(CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .num_cycles  (num_cycles),
        .cpu_read_reg(cpu_read_reg),
        .read_reg    (read_reg),
        .read_data   (read_data),
        .exp_addr    (exp_addr),
        .exp_data    (exp_data),
        .cpu_hold    (cpu_hold),
        .dump_valid  (dump_valid),
        .dump_reg    (dump_reg),
        .dump_data   (dump_data),
        .mismatch    (mismatch),
        .dump_exp    (dump_exp),
        .cycle_count (cycle_count),
        .error_count (error_count),
        .busy        (busy),
        .done        (done),
        .pass        (pass)
    );

    always #5 clock = ~clock;

    assign read_data = regfile[read_reg];

    always @(posedge clock) exp_data <= rom[exp_addr];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".hold"},  64'(cpu_hold),    64'(1));
        check_eq({tag, ".busy"},  64'(busy),        64'(0));
        check_eq({tag, ".done"},  64'(done),        64'(0));
        check_eq({tag, ".pass"},  64'(pass),        64'(0));
        check_eq({tag, ".dv"},    64'(dump_valid),  64'(0));
        check_eq({tag, ".dreg"},  64'(dump_reg),    64'(0));
        check_eq({tag, ".ddata"}, 64'(dump_data),   64'(0));
        check_eq({tag, ".dexp"},  64'(dump_exp),    64'(0));
        check_eq({tag, ".mm"},    64'(mismatch),    64'(0));
        check_eq({tag, ".cyc"},   64'(cycle_count), 64'(0));
        check_eq({tag, ".err"},   64'(error_count), 64'(0));
        check_eq({tag, ".rreg"},  64'(read_reg),    64'(cpu_read_reg));
    endtask

    // Timeline after an accepted start: cycles 0..n-1 run, n..n+NR-1 sweep,
    // n+NR drain, from n+NR+1 done; register i is dumped in cycle n+1+i.
    task automatic check_cycle(input string tag, input int n, input bit md, input int k, inout int err);
        bit            in_run;
        bit            in_check;
        bit            fin;
        bit            dv;
        bit            wm;
        int            idx;
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
        logic [DW-1:0] we;
        string         t;
        in_run   = (k < n);
        in_check = (k >= n) && (k < n + NR);
        fin      = (k >= n + NR + 1);
        dv       = (k >= n + 1) && (k <= n + NR);
        idx      = k - n - 1;
        wr = '0;
        wd = '0;
        we = '0;
        wm = 1'b0;
        if (dv) begin
            wr = idx[AW-1:0];
            wd = regfile[idx];
            we = rom[idx];
            wm = md && (wd != we);
        end
        t = $sformatf("%s@%0d", tag, k);
        check_eq({t, ".hold"},  64'(cpu_hold),    64'(!in_run));
        check_eq({t, ".busy"},  64'(busy),        64'(!fin));
        check_eq({t, ".done"},  64'(done),        64'(fin));
        check_eq({t, ".rreg"},  64'(read_reg),    in_check ? 64'(k - n) : 64'(cpu_read_reg));
        check_eq({t, ".eaddr"}, 64'(exp_addr),    in_check ? 64'(k - n) : 64'(exp_addr));
        check_eq({t, ".dv"},    64'(dump_valid),  64'(dv));
        check_eq({t, ".dreg"},  64'(dump_reg),    64'(wr));
        check_eq({t, ".ddata"}, 64'(dump_data),   64'(wd));
        check_eq({t, ".dexp"},  64'(dump_exp),    64'(we));
        check_eq({t, ".mm"},    64'(mismatch),    64'(wm));
        check_eq({t, ".cyc"},   64'(cycle_count), in_run ? 64'(k) : 64'(n));
        check_eq({t, ".err"},   64'(error_count), 64'(err));
        check_eq({t, ".pass"},  64'(pass),        64'(fin && (!md || err == 0)));
        if (wm) err++;
    endtask

    // Runs one full sweep; glitch_k pulses start during that cycle, reset_k asserts
    // reset during that cycle and ends the run there (-1 disables either).
    task automatic do_run(input string tag, input int n, input bit md, input int glitch_k, input int reset_k);
        int err;
        err = 0;
        @(negedge clock);
        num_cycles = CW'(n);
        mode       = md;
        start      = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < n + NR + 2; k++) begin
            check_cycle(tag, n, md, k, err);
            if (k == reset_k) begin
                reset = 1'b1;
                #1;
                check_idle({tag, ".rst_now"});
                @(negedge clock);
                check_idle({tag, ".rst_held"});
                reset = 1'b0;
                @(negedge clock);
                check_idle({tag, ".rst_idle"});
                return;
            end
            cpu_read_reg = AW'($urandom);
            num_cycles   = CW'($urandom);
            mode         = 1'($urandom_range(1, 0));
            start        = (k == glitch_k);
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            regfile[i] = $urandom;
            rom[i]     = regfile[i];
        end
        @(negedge clock);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clock);
        check_idle("idle");

        do_run("budget", 5, 1'b1, -1, -1);
        check_eq("budget.done", 64'(done), 64'(1));
        check_eq("budget.pass", 64'(pass), 64'(1));
        check_eq("budget.err",  64'(error_count), 64'(0));
        check_eq("budget.cyc",  64'(cycle_count), 64'(5));

        rom[3]      = 32'd7;
        regfile[3]  = 32'd9;
        rom[17]     = regfile[17] ^ 32'h0000_0100;
        do_run("cmp", 3, 1'b1, -1, -1);
        check_eq("cmp.err",  64'(error_count), 64'(2));
        check_eq("cmp.pass", 64'(pass), 64'(0));

        do_run("dump", 4, 1'b0, -1, -1);
        check_eq("dump.err",  64'(error_count), 64'(0));
        check_eq("dump.pass", 64'(pass), 64'(1));

        do_run("zero", 0, 1'b1, -1, -1);
        check_eq("zero.cyc", 64'(cycle_count), 64'(0));
        check_eq("zero.err", 64'(error_count), 64'(2));

        do_run("glitch", 2, 1'b1, 12, -1);
        check_eq("glitch.err", 64'(error_count), 64'(2));

        rom[3] = regfile[3];
        do_run("rerun", 6, 1'b1, -1, -1);
        check_eq("rerun.err",  64'(error_count), 64'(1));
        check_eq("rerun.pass", 64'(pass), 64'(0));

        do_run("midrst", 3, 1'b1, -1, 3 + 20);
        do_run("postrst", 2, 1'b1, -1, -1);

        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 4; j++) begin
                int unsigned p;
                p = $urandom_range(NR - 1, 0);
                if ($urandom_range(1, 0) == 1) rom[p] = $urandom;
                else rom[p] = regfile[p];
            end
            do_run($sformatf("rand%0d", r), int'($urandom_range(12, 0)), 1'($urandom_range(1, 0)), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_check_harness.md
REG_CHECK_HARNESS -- requirements
Module: reg_check_harness

Interface
REQ-001 Parameter DATA_WIDTH, default 32: regfile and expected-value word width.
REQ-002 Parameter NUM_REGS, default 32: registers swept in the check phase; ADDR_WIDTH = clog2(NUM_REGS), default 5.
REQ-003 Parameter CYCLE_WIDTH, default 14: width of the run-cycle budget and counter.
REQ-004 Clocking is fixed: one clock, `clock`; reset is `reset`, asynchronous and active-high.
REQ-005 Ports, as name direction width meaning:
- clock  in  1  sole clock.
- reset  in  1  async active-high reset.
- start  in  1  begins a run; sampled only in IDLE or DONE.
- mode  in  1  0 = dump only, 1 = dump and compare; latched at start.
- num_cycles  in  CYCLE_WIDTH  processor run budget; latched at start.
- cpu_read_reg  in  ADDR_WIDTH  processor's port-A read select.
- read_reg  out  ADDR_WIDTH  regfile port-A select after the mux.
- read_data  in  DATA_WIDTH  regfile port-A data, combinational.
- exp_addr  out  ADDR_WIDTH  expected-value ROM address.
- exp_data  in  DATA_WIDTH  ROM data, valid one cycle after exp_addr.
- cpu_hold  out  1  holds the processor in reset/stall.
- dump_valid, dump_reg, dump_data  out  1/ADDR_WIDTH/DATA_WIDTH  one captured register per cycle.
- mismatch  out  1  compare failure this cycle, qualified by dump_valid.
- dump_exp  out  DATA_WIDTH  expected value paired with dump_data.
- cycle_count  out  CYCLE_WIDTH  RUN cycles elapsed.
- error_count  out  ADDR_WIDTH+1  mismatches counted.
- busy, done, pass  out  1  status.

Function
REQ-006 The FSM SHALL have five states, IDLE, RUN, CHECK, DRAIN, DONE, with transitions:
- IDLE/DONE + start: go to RUN, or to CHECK if num_cycles == 0.
- RUN: stay exactly num_cycles cycles, then go to CHECK.
- CHECK: stay exactly NUM_REGS cycles, then go to DRAIN.
- DRAIN: one cycle, then go to DONE.
- DONE: hold until start.
REQ-007 Accepting start SHALL clear cycle_count, error_count, done and pass; start in RUN, CHECK or DRAIN SHALL be ignored.
REQ-008 cpu_hold SHALL be 0 only in RUN.
REQ-009 cycle_count SHALL increment once per RUN cycle, ending equal to num_cycles and holding after RUN.
REQ-010 read_reg SHALL equal cpu_read_reg outside CHECK, and the sweep index (0 up to NUM_REGS-1, one per cycle) in CHECK; exp_addr SHALL equal the sweep index.
REQ-011 A capture stage SHALL register (index, read_data, valid) at each CHECK edge; dump_valid SHALL be that stored valid.
REQ-012 Dump output timing and content:
- dump_valid SHALL be high exactly NUM_REGS cycles: CHECK cycles 2..NUM_REGS plus DRAIN.
- dump_reg and dump_data SHALL come from the stored index and value.
- dump_exp SHALL equal exp_data in that cycle.
REQ-013 mismatch SHALL be dump_valid && mode && (dump_data != dump_exp); each mismatch SHALL increment error_count at the following edge.
REQ-014 busy SHALL be high in RUN, CHECK and DRAIN; done SHALL be high only in DONE.
REQ-015 In DONE, pass SHALL be 1 iff mode == 0 or error_count == 0; it SHALL be 0 in every other state.
REQ-016 Outputs with no valid data SHALL drive 0: dump_* when dump_valid is low, and mismatch.

Reset
REQ-017 Asserting reset SHALL immediately, at any point including mid-RUN or mid-CHECK:
- force the FSM to IDLE;
- zero all counters, the capture stage and the latched mode/budget;
- drive cpu_hold=1 and busy=done=pass=0.
REQ-018 The first start after reset deasserts SHALL behave identically to a start from DONE.

Structure
REQ-019 The FSM state encoding and the parameter defaults SHALL live in the shared package reg_check_pkg.
REQ-020 The capture-and-compare pipeline SHALL be a single sub-module, reg_check_stage; the FSM, counters and muxes SHALL stay in reg_check_harness.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Budget run: num_cycles=5, mode=1, ROM matching the regfile -> cpu_hold low exactly 5 cycles; 32 dump_valid pulses with regs 0..31 in order; done=1, pass=1, error_count=0.
- Compare: ROM r3=7, regfile r3=9, r17 also differing -> mismatch only at dump_reg 3 and 17; error_count=2; pass=0.
- Dump mode: mode=0 with the same mismatches -> mismatch never asserted; error_count=0; pass=1.
- Zero budget: num_cycles=0 -> no RUN cycle; CHECK follows start directly; cycle_count=0.
- Start handling: start pulsed mid-CHECK -> ignored; a second start in DONE reruns and clears counts.
- Mid-run reset: reset asserted in CHECK -> IDLE immediately, cpu_hold=1, dump_valid=0, counts zero.
